// File: rtl/sync_fifo_param_if.sv
// Handshake and status bundle for sync_fifo_param.
// The producer/consumer side uses the master modport; the FIFO uses slave.
interface sync_fifo_param_if #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16
);
  localparam int ADDR_W = $clog2(DEPTH);

  logic                  write_enable;
  logic [DATA_WIDTH-1:0] write_data;
  logic                  read_enable;
  logic [DATA_WIDTH-1:0] read_data;
  logic                  read_valid;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic                  almost_full;
  logic                  almost_empty;
  logic [ADDR_W:0]       fill_count;
  logic                  overflow;
  logic                  underflow;

  modport master (
    output write_enable, write_data, read_enable,
    input  read_data, read_valid, fifo_full, fifo_empty,
           almost_full, almost_empty, fill_count, overflow, underflow
  );

  modport slave (
    input  write_enable, write_data, read_enable,
    output read_data, read_valid, fifo_full, fifo_empty,
           almost_full, almost_empty, fill_count, overflow, underflow
  );
endinterface

// File: rtl/sync_fifo_param.sv
// Single-clock parametrised FIFO with occupancy count, almost-full/empty
// thresholds and registered overflow/underflow error pulses.
// Read data is registered: one clock from read_enable to read_data/read_valid.
// Status flags are decoded from the registered fill count.
module sync_fifo_param #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16,
  parameter int AF_THRESH  = 14,
  parameter int AE_THRESH  = 2
) (
  input  logic               clk,
  input  logic               reset,
  sync_fifo_param_if.slave   bus
);

  localparam int ADDR_W = $clog2(DEPTH);

  // Thresholds sized to the count so every compare is width-matched.
  localparam logic [ADDR_W:0] DEPTH_C = DEPTH[ADDR_W:0];
  localparam logic [ADDR_W:0] AF_C    = AF_THRESH[ADDR_W:0];
  localparam logic [ADDR_W:0] AE_C    = AE_THRESH[ADDR_W:0];

  // Storage
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  // Control state
  logic [ADDR_W-1:0]     wptr_q,   wptr_d;
  logic [ADDR_W-1:0]     rptr_q,   rptr_d;
  logic [ADDR_W:0]       count_q,  count_d;
  logic [DATA_WIDTH-1:0] rdata_q,  rdata_d;
  logic                  rvalid_q, rvalid_d;
  logic                  ovf_q,    ovf_d;
  logic                  udf_q,    udf_d;

  // Handshake decode
  logic full_w;
  logic empty_w;
  logic wr_acc;
  logic rd_acc;

  assign full_w  = (count_q == DEPTH_C);
  assign empty_w = (count_q == '0);

  // A read needs data already stored (no write-to-read bypass); a write into
  // a full FIFO is allowed only when a read frees a slot in the same cycle.
  assign rd_acc = bus.read_enable  && !empty_w;
  assign wr_acc = bus.write_enable && (!full_w || rd_acc);

  // Next-state computation for pointers, count, read data and error pulses.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // leaves a signal unassigned and no latch is inferred.
    wptr_d   = wptr_q;
    rptr_d   = rptr_q;
    count_d  = count_q;
    rdata_d  = rdata_q;
    rvalid_d = 1'b0;
    ovf_d    = bus.write_enable && !wr_acc;
    udf_d    = bus.read_enable  && !rd_acc;

    if (wr_acc) begin
      wptr_d = wptr_q + 1'b1;   // natural wrap at DEPTH (power of two)
    end

    if (rd_acc) begin
      rptr_d   = rptr_q + 1'b1;
      rdata_d  = mem_q[rptr_q];
      rvalid_d = 1'b1;
    end

    unique case ({wr_acc, rd_acc})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;       // both or neither: occupancy unchanged
    endcase
  end

  // Control registers with asynchronous reset.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (reset) begin
      wptr_q   <= '0;
      rptr_q   <= '0;
      count_q  <= '0;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      wptr_q   <= wptr_d;
      rptr_q   <= rptr_d;
      count_q  <= count_d;
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
    end
  end

  // Storage write port.
  always_ff @(posedge clk) begin
    // NOTE: the array has no reset; pointers and count define which entries
    // are valid, and leaving it unreset lets it map onto RAM.
    if (wr_acc) begin
      mem_q[wptr_q] <= bus.write_data;
    end
  end

  // Outputs
  assign bus.read_data    = rdata_q;
  assign bus.read_valid   = rvalid_q;
  assign bus.fill_count   = count_q;
  assign bus.fifo_full    = full_w;
  assign bus.fifo_empty   = empty_w;
  assign bus.almost_full  = (count_q >= AF_C);
  assign bus.almost_empty = (count_q <= AE_C);
  assign bus.overflow     = ovf_q;
  assign bus.underflow    = udf_q;

endmodule

// File: doc/sync_fifo_param.md
Name: sync_fifo_param

Overview:
- Single-clock, parametrised FIFO buffer; the synchronous successor to the team's fixed 8-bit FIFO.
- Generalised in data width and depth.
- Adds occupancy count, programmable almost-full/almost-empty thresholds, and overflow/underflow error pulses.
- Used as the standard buffering element inside one clock domain, e.g. between producer and consumer pipelines.

Parameters:
- DATA_WIDTH, 8: width of write_data/read_data in bits (>=1).
- DEPTH, 16: number of entries; power of two, >=2; ADDR_W = clog2(DEPTH).
- AF_THRESH, 14: almost_full asserts when fill_count >= AF_THRESH (1..DEPTH).
- AE_THRESH, 2: almost_empty asserts when fill_count <= AE_THRESH (0..DEPTH-1).

Ports:
- clk  input  1  sole clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- write_enable  input  1  write request this cycle.
- write_data  input  DATA_WIDTH  data written when the write is accepted.
- read_enable  input  1  read request this cycle.
- read_data  output  DATA_WIDTH  registered read data.
- read_valid  output  1  one-cycle pulse: read_data holds a newly read word.
- fifo_full  output  1  fill_count == DEPTH.
- fifo_empty  output  1  fill_count == 0.
- almost_full  output  1  fill_count >= AF_THRESH.
- almost_empty  output  1  fill_count <= AE_THRESH.
- fill_count  output  ADDR_W+1  current occupancy, 0..DEPTH.
- overflow  output  1  one-cycle pulse: a write was rejected.
- underflow  output  1  one-cycle pulse: a read was rejected.

Behaviour:
- Reset, asynchronous and taking effect immediately:
  - write/read pointers = 0, fill_count = 0, read_data = 0;
  - read_valid, overflow, underflow, fifo_full, almost_full = 0 (AF_THRESH >= 1);
  - fifo_empty = 1, almost_empty = 1.
  - Memory array is not reset.
  - Reset mid-operation discards all contents; the first cycle after release behaves as an empty FIFO.
- Write acceptance, wr_acc:
  - wr_acc = write_enable && (!fifo_full || rd_acc).
  - When full, a write is accepted only if a read is accepted in the same cycle.
- Read acceptance, rd_acc:
  - rd_acc = read_enable && !fifo_empty.
  - No bypass: a read on an empty FIFO is rejected even if a write happens in the same cycle.
- Accepted write: mem[wptr] <= write_data; wptr increments modulo DEPTH (natural wrap of ADDR_W bits).
- Accepted read:
  - read_data <= mem[rptr]; rptr increments modulo DEPTH.
  - read_valid = 1 in the following cycle.
  - Latency: one clock from read_enable sample to read_data/read_valid.
  - read_data holds its last value when no read occurs.
- fill_count update:
  - +1 on wr_acc only; -1 on rd_acc only; unchanged when both or neither.
- Status flags (full, empty, almost_*):
  - Decoded from the registered fill_count, so they update in the same cycle as fill_count.
  - They reflect state after the previous edge.
- Error pulses:
  - overflow <= write_enable && !wr_acc.
  - underflow <= read_enable && !rd_acc.
  - Each is registered: a single-cycle pulse per rejected request, asserted the cycle after it.
  - Rejected operations change no pointer, count or data.
- Ordering: strict first-in first-out; data integrity across pointer wrap-around.

Test Plan:
1. Reset, then idle -> fifo_empty=1, almost_empty=1, fill_count=0, read_valid=0, read_data=0, overflow=underflow=0.
2. Write 0xCA then 0xAA, then read twice -> read_data 0xCA then 0xAA, each with a read_valid pulse one cycle after its read; fill_count goes 1, 2, 1, 0; fifo_empty returns to 1.
3. Write 16 words 0x00..0x0F (DEPTH=16), then assert write_enable with 0xFF:
   - almost_full rises when fill_count reaches 14; fifo_full=1 at 16;
   - the 0xFF write produces an overflow pulse and fill_count stays 16;
   - draining then returns 0x00..0x0F in order.
4. Full FIFO, simultaneous write 0x55 and read -> both accepted; fill_count stays 16, no overflow. Empty FIFO, simultaneous write 0x33 and read -> underflow pulse; fill_count becomes 1; the next read returns 0x33.
5. Wrap-around: stream 40 sequential words with interleaved reads keeping occupancy 3..10 -> output sequence identical to input; almost_empty asserted exactly when fill_count <= 2.
6. Write 5 words, assert reset asynchronously mid-cycle -> all outputs at reset values immediately, fill_count=0; a subsequent write/read of 0x77 returns 0x77.
